fsk_modulator: RTL and testbench
================================

FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 SHALL have parameter FREQ_WORD_0, default 16'd1024: phase increment per sample for bit 0.
REQ-002 SHALL have parameter FREQ_WORD_1, default 16'd2048: phase increment per sample for bit 1.
REQ-003 SHALL have parameter SAMPLES_PER_BIT, default 64 (range 2..65535): output samples per symbol.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bit_in  input  1  data bit to modulate.
REQ-007 SHALL have port bit_valid  input  1  bit_in is valid.
REQ-008 SHALL have port bit_ready  output  1  bit accepted on any edge where bit_valid and bit_ready are both 1.
REQ-009 SHALL have port mod_data  output  16  signed two's-complement sine sample, feeding the float conversion stage.
REQ-010 SHALL have port mod_valid  output  1  mod_data holds a valid sample this cycle.

Function
REQ-011 SHALL implement FSM states IDLE and RUN, plus a 16-bit phase accumulator, a 16-bit sample counter cnt and a registered current bit.
REQ-012 SHALL drive bit_ready combinationally: 1 in IDLE; 1 in RUN only when cnt == SAMPLES_PER_BIT-1; 0 otherwise.
REQ-013 SHALL, on accept in IDLE: latch bit, cnt<=0, enter RUN, keep mod_valid<=0 that edge.
REQ-014 SHALL, on each RUN edge: mod_data <= LUT[phase[15:8]], mod_valid <= 1, phase <= phase + FREQ_WORD of current bit (mod 2^16 wrap), cnt <= cnt+1.
REQ-015 SHALL, on a RUN edge with cnt == SAMPLES_PER_BIT-1 and a new accept: emit last sample, latch new bit, cnt<=0, stay RUN (gapless output).
REQ-016 SHALL, on a RUN edge with cnt == SAMPLES_PER_BIT-1 and no accept: emit last sample, enter IDLE.
REQ-017 SHALL, on IDLE edges without accept: mod_valid <= 0, mod_data <= 0.
REQ-018 SHALL have latency of exactly 1 clk from accept edge to first valid sample; exactly SAMPLES_PER_BIT valid samples per accepted bit.
REQ-019 SHALL hold a 256-entry ROM LUT[k] = round(32767*sin(2*pi*k/256)), signed 16-bit; LUT[64]=32767, LUT[192]=-32767.
REQ-020 SHALL ignore bit_valid while bit_ready is 0; bit_in is sampled only on accept.

Reset
REQ-021 SHALL, while rst=1, force IDLE, phase=0, cnt=0, current bit=0, mod_data=0, mod_valid=0, with bit_ready=1 immediately (asynchronous).
REQ-022 SHALL abort a symbol in progress on reset mid-RUN; no remaining samples emitted; no bit accepted while rst=1.

Configuration
REQ-023 SHALL, with macro FSK_CONT_PHASE_EN defined, keep phase across accepts (continuous-phase FSK); phase cleared only by reset.
REQ-024 SHALL, without FSK_CONT_PHASE_EN, clear phase to 0 on every accept so each symbol starts at LUT[0].

Verification (SAMPLES_PER_BIT=64, FREQ_WORD_0=1024, FREQ_WORD_1=2048 unless noted)
REQ-025 SHALL cover: rst pulse mid-symbol with bit_valid=1 -> mod_valid=0, mod_data=0 immediately; bit_ready=1; no accept during rst.
REQ-026 SHALL cover: single bit 0 from IDLE -> mod_valid high 64 cycles starting 1 clk after accept; sample0=0, sample16=32767, sample32=0, sample48=-32767; then mod_valid=0, mod_data=0.
REQ-027 SHALL cover: single bit 1 -> sample8=32767, sample24=-32767, sample32=0; 64 samples total.
REQ-028 SHALL cover: bits 0,1 back-to-back with FREQ_WORD_0=1000 -> mod_valid continuously high 128 cycles; sample64=0 without FSK_CONT_PHASE_EN, sample64=LUT[250]=-4808 with it.
REQ-029 SHALL cover: bit_valid dropped at end of symbol -> IDLE after sample63; mod_valid low; a later accept produces first sample exactly 1 clk later.
REQ-030 SHALL cover: bit_valid held high with toggling bit_in while cnt<63 -> bit_ready=0, bit_in changes ignored; new bit taken only at cnt=63.

Source files
------------

// File: rtl/fsk_modulator_if.sv
// fsk_modulator_if: bit-stream input and sample-stream output of the FSK modulator.
//
// Signals:
//   bit_in     data bit to modulate (sampled only on accept)
//   bit_valid  bit_in is valid
//   bit_ready  modulator can take a bit this cycle (accept = bit_valid & bit_ready)
//   mod_data   signed 16-bit sine sample
//   mod_valid  mod_data holds a valid sample this cycle
//
// Modports: master = bit source / sample sink, slave = the modulator.
interface fsk_modulator_if;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] mod_data;
  logic               mod_valid;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready,
    input  mod_data,
    input  mod_valid
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready,
    output mod_data,
    output mod_valid
  );
endinterface

// File: rtl/fsk_modulator.sv
// fsk_modulator: binary FSK modulator. Each accepted bit produces SAMPLES_PER_BIT sine samples
// read from a 256-entry ROM indexed by the top byte of a 16-bit phase accumulator, which
// advances by FREQ_WORD_0 or FREQ_WORD_1 per sample depending on the bit. A new bit can be
// taken on the last sample of the current symbol, giving a gapless output stream.
//
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  fsk_modulator_if.slave (bit_in/bit_valid/bit_ready in, mod_data/mod_valid out)
//
// Optional feature (macro FSK_CONT_PHASE_EN): when defined, the phase accumulator carries
// across symbols (continuous-phase FSK) and is cleared only by reset. When undefined, every
// accepted bit restarts the phase at 0 so each symbol begins at LUT[0].
module fsk_modulator #(
  parameter logic [15:0] FREQ_WORD_0     = 16'd1024,
  parameter logic [15:0] FREQ_WORD_1     = 16'd2048,
  parameter int unsigned SAMPLES_PER_BIT = 64
) (
  input logic            clk,
  input logic            rst,
  fsk_modulator_if.slave bus
);

  localparam logic [15:0] CntLast = 16'(SAMPLES_PER_BIT - 1);

  // First quarter of round(32767*sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry.
  localparam logic [15:0] QuarterLut [65] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  // Full 256-entry sine ROM folded onto the quarter table: odd quadrants mirror the index,
  // the lower half of the circle (idx[7]) negates.
  function automatic logic signed [15:0] sine_lut(input logic [7:0] idx);
    logic [6:0]  q;
    logic [15:0] mag;
    q   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = QuarterLut[q];
    return idx[7] ? -$signed(mag) : $signed(mag);
  endfunction

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [15:0]        phase_q, phase_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               bit_q, bit_d;
  logic signed [15:0] mod_data_q, mod_data_d;
  logic               mod_valid_q, mod_valid_d;

  logic        last_sample;
  logic        bit_ready;
  logic        accept;
  logic [15:0] phase_step;
  logic [15:0] phase_sum;
  logic [15:0] phase_restart_idle;
  logic [15:0] phase_restart_run;

  assign last_sample = (cnt_q == CntLast);
  assign bit_ready   = (state_q == StIdle) || last_sample;
  assign accept      = bus.bit_valid && bit_ready;
  assign phase_step  = bit_q ? FREQ_WORD_1 : FREQ_WORD_0;
  assign phase_sum   = phase_q + phase_step;

`ifdef FSK_CONT_PHASE_EN
  // Phase carries straight on into the next symbol.
  assign phase_restart_idle = phase_q;
  assign phase_restart_run  = phase_sum;
`else
  assign phase_restart_idle = '0;
  assign phase_restart_run  = '0;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    mod_data_d  = mod_data_q;
    mod_valid_d = mod_valid_q;
    unique case (state_q)
      StIdle: begin
        mod_valid_d = 1'b0;
        mod_data_d  = '0;
        if (accept) begin
          bit_d   = bus.bit_in;
          cnt_d   = '0;
          phase_d = phase_restart_idle;
          state_d = StRun;
        end
      end
      StRun: begin
        mod_data_d  = sine_lut(phase_q[15:8]);
        mod_valid_d = 1'b1;
        phase_d     = phase_sum;
        cnt_d       = cnt_q + 16'd1;
        if (last_sample) begin
          cnt_d = '0;
          if (accept) begin
            bit_d   = bus.bit_in;
            phase_d = phase_restart_run;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      cnt_q       <= '0;
      bit_q       <= 1'b0;
      mod_data_q  <= '0;
      mod_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      mod_data_q  <= mod_data_d;
      mod_valid_q <= mod_valid_d;
    end
  end

  assign bus.bit_ready = bit_ready;
  assign bus.mod_data  = mod_data_q;
  assign bus.mod_valid = mod_valid_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// tb_fsk_modulator: two modulators (FREQ_WORD_0 = 1024 and 1000) driven with identical bit
// streams and compared each cycle against a symbol-level reference model that computes the
// sine from $sin. Scenario tasks add fixed-value checks on landmark samples.
module tb_fsk_modulator;
  localparam int Spb = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fsk_modulator_if if_a ();
  fsk_modulator_if if_b ();

  fsk_modulator #(
    .FREQ_WORD_0(16'd1024), .FREQ_WORD_1(16'd2048), .SAMPLES_PER_BIT(Spb)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );

  fsk_modulator #(
    .FREQ_WORD_0(16'd1000), .FREQ_WORD_1(16'd2048), .SAMPLES_PER_BIT(Spb)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  int checks = 0;
  int errors = 0;

  int   lut [256];
  int   fw0 [2] = '{1024, 1000};
  int   m_left;          // samples still owed for the current symbol
  logic m_bit;
  int   m_phase [2];
  logic m_valid;
  int   m_data [2];
  logic m_acc;
  int   n_acc;
  logic drv_valid, drv_bit;

  function automatic int ref_sine(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic drive(input logic v, input logic b);
    drv_valid = v;
    drv_bit   = b;
    if_a.bit_valid = v;
    if_a.bit_in    = b;
    if_b.bit_valid = v;
    if_b.bit_in    = b;
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_bit   = 1'b0;
    m_phase = '{0, 0};
    m_valid = 1'b0;
    m_data  = '{0, 0};
  endtask

  // Advance one rising edge, update the model, return 1 time unit after the edge.
  task automatic clock_edge();
    m_acc = drv_valid && (m_left <= 1) && !rst;
    @(posedge clk);
    if (m_left > 0) begin
      m_valid = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_data[d]  = lut[m_phase[d] / 256];
        m_phase[d] = (m_phase[d] + (m_bit ? 2048 : fw0[d])) % 65536;
      end
      m_left--;
    end else begin
      m_valid = 1'b0;
      m_data  = '{0, 0};
    end
    if (m_acc) begin
      n_acc++;
      m_bit  = drv_bit;
      m_left = Spb;
`ifndef FSK_CONT_PHASE_EN
      m_phase = '{0, 0};
`endif
    end
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    model_reset();
    clock_edge();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0);
    model_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({if_a.mod_valid, if_a.mod_data, if_a.bit_ready} !== {1'b0, 16'sd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_init: got v=%b d=%0d r=%b, want 0/0/1", if_a.mod_valid,
               $signed(if_a.mod_data), if_a.bit_ready);
    end
    drive(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      clock_edge();
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !== 34'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got a=%b/%0d b=%b/%0d, want 0/0", i, if_a.mod_valid,
                 $signed(if_a.mod_data), if_b.mod_valid, $signed(if_b.mod_data));
      end
    end
    #1 rst = 1'b0;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL reset_run_ready cyc %0d: got %b%b, want %b", i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL reset_run_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
    end
    // Asynchronous reset mid-symbol with bit_valid still high.
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({if_a.mod_valid, if_a.mod_data, if_a.bit_ready, if_b.mod_valid, if_b.bit_ready} !==
        {1'b0, 16'sd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%0d r=%b, want 0/0/1", if_a.mod_valid,
               $signed(if_a.mod_data), if_a.bit_ready);
    end
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !== 34'd0) begin
        errors++;
        $display("FAIL reset_no_accept cyc %0d: got a=%b/%0d, want 0/0", i, if_a.mod_valid,
                 $signed(if_a.mod_data));
      end
    end
    #1 rst = 1'b0;
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_a.bit_ready} !== {1'b0, 16'sd0, 1'b1}) begin
        errors++;
        $display("FAIL reset_after cyc %0d: got v=%b d=%0d r=%b, want 0/0/1", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_a.bit_ready);
      end
    end
  endtask

  task automatic test_single_bit(input logic b);
    int cap[$];
    int first;
    first = -1;
    pulse_reset();
    drive(1'b1, b);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL single%0d_ready cyc %0d: got %b%b, want %b", b, i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      drive(1'b0, 1'b0);
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL single%0d_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", b, i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
      if (if_a.mod_valid === 1'b1) begin
        if (first < 0) first = i;
        cap.push_back(int'($signed(if_a.mod_data)));
      end
    end
    checks++;
    if (cap.size() != Spb || first != 1) begin
      errors++;
      $display("FAIL single%0d_count: got %0d samples from cyc %0d, want 64 from cyc 1", b,
               cap.size(), first);
    end
    if (cap.size() >= Spb) begin
      int idx [4];
      int exp_v [4];
      if (b == 1'b0) begin
        idx = '{0, 16, 32, 48};
        exp_v = '{0, 32767, 0, -32767};
      end else begin
        idx = '{0, 8, 24, 32};
        exp_v = '{0, 32767, -32767, 0};
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap[idx[k]] != exp_v[k]) begin
          errors++;
          $display("FAIL single%0d_sample%0d: got %0d, want %0d", b, idx[k], cap[idx[k]],
                   exp_v[k]);
        end
      end
    end
    checks++;
    if ({if_a.mod_valid, if_a.mod_data} !== 17'd0) begin
      errors++;
      $display("FAIL single%0d_idle: got %b/%0d, want 0/0", b, if_a.mod_valid,
               $signed(if_a.mod_data));
    end
  endtask

  task automatic test_back_to_back();
    int cap_b[$];
    int first, last, exp64;
`ifdef FSK_CONT_PHASE_EN
    exp64 = -4808;
`else
    exp64 = 0;
`endif
    first = -1;
    last  = -1;
    pulse_reset();
    n_acc = 0;
    drive(1'b1, 1'b0);
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL b2b_ready cyc %0d: got %b%b, want %b", i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      if (n_acc == 1) drive(1'b1, 1'b1);
      else if (n_acc >= 2) drive(1'b0, 1'b0);
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL b2b_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
      if (if_b.mod_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        cap_b.push_back(int'($signed(if_b.mod_data)));
      end
    end
    checks++;
    if (cap_b.size() != 2 * Spb || last - first != 2 * Spb - 1) begin
      errors++;
      $display("FAIL b2b_continuous: got %0d samples over cyc %0d..%0d, want 128 contiguous",
               cap_b.size(), first, last);
    end
    if (cap_b.size() > Spb) begin
      checks++;
      if (cap_b[Spb] != exp64) begin
        errors++;
        $display("FAIL b2b_sample64: got %0d, want %0d", cap_b[Spb], exp64);
      end
    end
  endtask

  task automatic test_idle_gap();
    int first2;
    first2 = -1;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL gap_ready cyc %0d: got %b%b, want %b", i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      if (i == 80) drive(1'b1, 1'b0);
      else drive(1'b0, 1'b0);
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL gap_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
      if (i > 70 && first2 < 0 && if_a.mod_valid === 1'b1) first2 = i;
    end
    checks++;
    if (first2 != 82) begin
      errors++;
      $display("FAIL gap_latency: got first sample at cyc %0d, want 82", first2);
    end
  endtask

  task automatic test_ignore_toggle();
    int vcount;
    vcount = 0;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 270; i++) begin
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL toggle_ready cyc %0d: got %b%b, want %b", i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      if (i < 199) drive(1'b1, 1'($urandom_range(0, 1)));
      else drive(1'b0, 1'b0);
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL toggle_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
      if (i < 200 && if_a.mod_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 199) begin
      errors++;
      $display("FAIL toggle_gapless: got %0d valid cycles, want 199", vcount);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2070; i++) begin
      if (i < 2000) drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      else drive(1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({if_a.bit_ready, if_b.bit_ready} !== {2{m_left <= 1}}) begin
        errors++;
        $display("FAIL rand_ready cyc %0d: got %b%b, want %b", i, if_a.bit_ready,
                 if_b.bit_ready, m_left <= 1);
      end
      clock_edge();
      checks++;
      if ({if_a.mod_valid, if_a.mod_data, if_b.mod_valid, if_b.mod_data} !==
          {m_valid, 16'(m_data[0]), m_valid, 16'(m_data[1])}) begin
        errors++;
        $display("FAIL rand_out cyc %0d: got a=%b/%0d b=%b/%0d, want %b/%0d/%0d", i,
                 if_a.mod_valid, $signed(if_a.mod_data), if_b.mod_valid,
                 $signed(if_b.mod_data), m_valid, m_data[0], m_data[1]);
      end
      if (i < 2000 && $urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({if_a.mod_valid, if_a.mod_data, if_a.bit_ready, if_b.bit_ready} !==
            {1'b0, 16'sd0, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL rand_reset cyc %0d: got v=%b d=%0d r=%b, want 0/0/1", i,
                   if_a.mod_valid, $signed(if_a.mod_data), if_a.bit_ready);
        end
        clock_edge();
        #1 rst = 1'b0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) lut[k] = ref_sine(k);
    n_acc = 0;
    m_acc = 1'b0;
    model_reset();
    drive(1'b0, 1'b0);
    test_reset();
    test_single_bit(1'b0);
    test_single_bit(1'b1);
    test_back_to_back();
    test_idle_gap();
    test_ignore_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
